// File: rtl/mem_seq_controller.sv
// Sequencer that owns the 16x4 game RAM: appends entries, replays them with timed
// show/gap windows and checks player inputs one entry at a time.
module mem_seq_controller #(
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_req,
  input  logic       append_req,
  input  logic [3:0] append_data,
  input  logic       play_req,
  input  logic       check_req,
  input  logic [3:0] check_data,
  input  logic [3:0] ram_q,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_data,
  output logic       busy,
  output logic [4:0] seq_len,
  output logic       full,
  output logic       show_valid,
  output logic [3:0] show_data,
  output logic       append_ack,
  output logic       play_done,
  output logic       match,
  output logic       mismatch,
  output logic       round_done,
  output logic       err
);

  localparam int unsigned CntMax = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] ShowLoad = CntW'(SHOW_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StPlayRd,
    StPlayShow,
    StPlayGap,
    StChkRd,
    StChkCmp
  } state_e;

  state_e          state;
  logic [3:0]      play_ptr;
  logic [3:0]      chk_ptr;
  logic [3:0]      check_latch;
  logic [CntW-1:0] cnt;
  logic            play_last;
  logic            chk_last;
  logic [3:0]      play_next;

  assign play_next = play_ptr + 4'd1;
  assign play_last = (({1'b0, play_ptr} + 5'd1) == seq_len);
  assign chk_last  = (({1'b0, chk_ptr} + 5'd1) == seq_len);
  assign full      = (seq_len == 5'd16);
  // RAM data only becomes visible while the show window is open.
  assign show_data = show_valid ? ram_q : 4'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      seq_len     <= '0;
      play_ptr    <= '0;
      chk_ptr     <= '0;
      check_latch <= '0;
      cnt         <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      busy        <= 1'b0;
      show_valid  <= 1'b0;
      append_ack  <= 1'b0;
      play_done   <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      round_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      append_ack <= 1'b0;
      play_done  <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
      err        <= 1'b0;

      unique case (state)
        StIdle: begin
          if (clear_req) begin
            seq_len <= '0;
            chk_ptr <= '0;
          end else if (append_req) begin
            if (full) begin
              err <= 1'b1;
            end else begin
              state    <= StWrite;
              busy     <= 1'b1;
              ram_we   <= 1'b1;
              ram_addr <= seq_len[3:0];
              ram_data <= append_data;
            end
          end else if (play_req) begin
            if (seq_len == 5'd0) begin
              play_done <= 1'b1;
            end else begin
              state    <= StPlayRd;
              busy     <= 1'b1;
              play_ptr <= '0;
              chk_ptr  <= '0;
              ram_addr <= '0;
            end
          end else if (check_req) begin
            if (seq_len == 5'd0) begin
              err <= 1'b1;
            end else begin
              state       <= StChkRd;
              busy        <= 1'b1;
              check_latch <= check_data;
              ram_addr    <= chk_ptr;
            end
          end
        end

        StWrite: begin
          ram_we     <= 1'b0;
          ram_data   <= '0;
          seq_len    <= seq_len + 5'd1;
          append_ack <= 1'b1;
          busy       <= 1'b0;
          state      <= StIdle;
        end

        StPlayRd: begin
          state      <= StPlayShow;
          show_valid <= 1'b1;
          cnt        <= ShowLoad;
        end

        StPlayShow: begin
          if (cnt == '0) begin
            state      <= StPlayGap;
            show_valid <= 1'b0;
            cnt        <= GapLoad;
            // Single-cycle gap: the next address must go out right now.
            if (GAP_CYCLES == 1 && !play_last) begin
              ram_addr <= play_next;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        StPlayGap: begin
          if (cnt == '0) begin
            if (play_last) begin
              state     <= StIdle;
              busy      <= 1'b0;
              play_ptr  <= '0;
              play_done <= 1'b1;
            end else begin
              state      <= StPlayShow;
              play_ptr   <= play_next;
              show_valid <= 1'b1;
              cnt        <= ShowLoad;
            end
          end else begin
            cnt <= cnt - 1'b1;
            // Prefetch during the final gap cycle so ram_q is ready when showing resumes.
            if (cnt == CntW'(1) && !play_last) begin
              ram_addr <= play_next;
            end
          end
        end

        StChkRd: begin
          state <= StChkCmp;
        end

        StChkCmp: begin
          state <= StIdle;
          busy  <= 1'b0;
          if (ram_q == check_latch) begin
            match <= 1'b1;
            if (chk_last) begin
              round_done <= 1'b1;
              chk_ptr    <= '0;
            end else begin
              chk_ptr <= chk_ptr + 4'd1;
            end
          end else begin
            mismatch <= 1'b1;
            chk_ptr  <= '0;
          end
        end

        default: begin
          state      <= StIdle;
          busy       <= 1'b0;
          ram_we     <= 1'b0;
          show_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq_controller.sv
// Directed bench for mem_seq_controller with a behavioural 16x4 synchronous RAM.
module tb_mem_seq_controller;

  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear_req, append_req, play_req, check_req;
  logic [3:0] append_data, check_data;
  logic [3:0] ram_q;
  logic       ram_we;
  logic [3:0] ram_addr, ram_data;
  logic       busy, full, show_valid;
  logic [4:0] seq_len;
  logic [3:0] show_data;
  logic       append_ack, play_done, match, mismatch, round_done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  logic [3:0] mem [16];
  logic [3:0] exp_seq [16];
  int         exp_len;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  mem_seq_controller #(
    .SHOW_CYCLES(SHOW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .append_req (append_req),
    .append_data(append_data),
    .play_req   (play_req),
    .check_req  (check_req),
    .check_data (check_data),
    .ram_q      (ram_q),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .seq_len    (seq_len),
    .full       (full),
    .show_valid (show_valid),
    .show_data  (show_data),
    .append_ack (append_ack),
    .play_done  (play_done),
    .match      (match),
    .mismatch   (mismatch),
    .round_done (round_done),
    .err        (err)
  );

  task automatic do_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  // lat = sample index (one per cycle after the request cycle) where ack/err appeared.
  task automatic do_append(input logic [3:0] d, output int lat, output logic got_ack,
                           output logic got_err);
    lat = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    @(negedge clk);
    append_req  = 1'b1;
    append_data = d;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      append_req = 1'b0;
      if (append_ack || err) begin
        lat = k;
        got_ack = append_ack;
        got_err = err;
        break;
      end
    end
  endtask

  // pul = {match, mismatch, round_done, err}
  task automatic do_check(input logic [3:0] d, output logic [3:0] pul, output int lat);
    lat = 0;
    pul = 4'b0;
    @(negedge clk);
    check_req  = 1'b1;
    check_data = d;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_req = 1'b0;
      if (match || mismatch || round_done || err) begin
        pul = {match, mismatch, round_done, err};
        lat = k;
        break;
      end
    end
  endtask

  // Samples every cycle until play_done and compares against the show/gap schedule.
  task automatic do_play(output int done_k, output int bad, output int shows);
    int   kd;
    int   idx;
    logic exp_v;
    logic [3:0] exp_d;
    done_k = 0;
    bad    = 0;
    shows  = 0;
    kd     = 2 + (SHOW + GAP) * exp_len;
    @(negedge clk);
    play_req = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      play_req = 1'b0;
      exp_v = 1'b0;
      exp_d = 4'd0;
      if (k >= 2) begin
        idx = k - 2;
        if (idx / (SHOW + GAP) < exp_len && idx % (SHOW + GAP) < SHOW) begin
          exp_v = 1'b1;
          exp_d = exp_seq[idx / (SHOW + GAP)];
        end
      end
      if (show_valid) shows++;
      if (show_valid !== exp_v || show_data !== exp_d || busy !== (k < kd)) bad++;
      if (play_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    clear_req = 1'b0; append_req = 1'b0; play_req = 1'b0; check_req = 1'b0;
    append_data = 4'd0; check_data = 4'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, ram_we, show_valid, append_ack, play_done, match, mismatch, round_done, err, full}
        !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0", {busy, ram_we, show_valid, append_ack,
               play_done, match, mismatch, round_done, err, full});
    end
    n_tests++;
    if ({seq_len, ram_addr, ram_data, show_data} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_values: seq_len=%0d addr=%0d data=%0d show=%0d want all 0",
               seq_len, ram_addr, ram_data, show_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || seq_len !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b seq_len=%0d want 0/0", busy, seq_len);
    end
  endtask

  task automatic test_append();
    logic [3:0] vals [3];
    int lat;
    logic a, e;
    vals[0] = 4'h5; vals[1] = 4'hA; vals[2] = 4'h3;
    for (int i = 0; i < 3; i++) begin
      do_append(vals[i], lat, a, e);
      n_tests++;
      if (lat !== 2 || a !== 1'b1 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL append_ack_%0d: lat=%0d ack=%b err=%b want 2/1/0", i, lat, a, e);
      end
      exp_seq[i] = vals[i];
    end
    exp_len = 3;
    n_tests++;
    if (seq_len !== 5'd3) begin
      n_fail++;
      $display("FAIL append_len: got %0d want 3", seq_len);
    end
    n_tests++;
    if (mem[0] !== 4'h5 || mem[1] !== 4'hA || mem[2] !== 4'h3) begin
      n_fail++;
      $display("FAIL append_ram: got %h %h %h want 5 a 3", mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_play();
    int done_k, bad, shows;
    do_play(done_k, bad, shows);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL play_pattern: %0d bad samples want 0", bad);
    end
    n_tests++;
    if (shows !== 12) begin
      n_fail++;
      $display("FAIL play_show_cycles: got %0d want 12", shows);
    end
    // Edges after the one that took the request.
    n_tests++;
    if (done_k - 1 !== 19) begin
      n_fail++;
      $display("FAIL play_done_latency: got %0d want 19", done_k - 1);
    end
    n_tests++;
    if (seq_len !== 5'd3) begin
      n_fail++;
      $display("FAIL play_len_kept: got %0d want 3", seq_len);
    end
  endtask

  task automatic test_check_round();
    logic [3:0] vals [4];
    logic [3:0] want [4];
    logic [3:0] pul;
    int lat;
    vals[0] = 4'h5; vals[1] = 4'hA; vals[2] = 4'h3; vals[3] = 4'h5;
    want[0] = 4'b1000; want[1] = 4'b1000; want[2] = 4'b1010; want[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      do_check(vals[i], pul, lat);
      n_tests++;
      if (pul !== want[i] || lat !== 3) begin
        n_fail++;
        $display("FAIL check_round_%0d: pulses=%b lat=%0d want %b/3", i, pul, lat, want[i]);
      end
    end
  endtask

  task automatic test_check_mismatch();
    logic [3:0] vals [4];
    logic [3:0] want [4];
    logic [3:0] pul;
    int lat;
    // Pointer sits at entry 1 (A) on entry.
    vals[0] = 4'h7; vals[1] = 4'h5; vals[2] = 4'h7; vals[3] = 4'h5;
    want[0] = 4'b0100; want[1] = 4'b1000; want[2] = 4'b0100; want[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      do_check(vals[i], pul, lat);
      n_tests++;
      if (pul !== want[i]) begin
        n_fail++;
        $display("FAIL check_mismatch_%0d: pulses=%b want %b", i, pul, want[i]);
      end
    end
  endtask

  task automatic test_full();
    int lat, bad_lat, bad_mem, we0;
    logic a, e;
    do_clear();
    bad_lat = 0;
    for (int i = 0; i < 16; i++) begin
      do_append(4'(i), lat, a, e);
      if (lat != 2 || !a) bad_lat++;
    end
    n_tests++;
    if (bad_lat !== 0) begin
      n_fail++;
      $display("FAIL full_appends: %0d bad appends want 0", bad_lat);
    end
    n_tests++;
    if (seq_len !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flag: seq_len=%0d full=%b want 16/1", seq_len, full);
    end
    bad_mem = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 4'(i)) bad_mem++;
    n_tests++;
    if (bad_mem !== 0) begin
      n_fail++;
      $display("FAIL full_ram: %0d wrong entries want 0", bad_mem);
    end
    we0 = we_cnt;
    do_append(4'hF, lat, a, e);
    repeat (2) @(negedge clk);
    n_tests++;
    if (e !== 1'b1 || a !== 1'b0 || lat !== 1 || we_cnt !== we0 || seq_len !== 5'd16) begin
      n_fail++;
      $display("FAIL full_overflow: err=%b ack=%b lat=%0d writes=%0d len=%0d want 1/0/1/0/16",
               e, a, lat, we_cnt - we0, seq_len);
    end
  endtask

  task automatic test_clear_append();
    int we0;
    logic seen;
    we0 = we_cnt;
    seen = 1'b0;
    @(negedge clk);
    clear_req   = 1'b1;
    append_req  = 1'b1;
    append_data = 4'h9;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      clear_req  = 1'b0;
      append_req = 1'b0;
      if (append_ack || busy || ram_we) seen = 1'b1;
    end
    n_tests++;
    if (seq_len !== 5'd0 || full !== 1'b0 || seen !== 1'b0 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL clear_priority: len=%0d full=%b activity=%b writes=%0d want 0/0/0/0",
               seq_len, full, seen, we_cnt - we0);
    end
  endtask

  task automatic test_empty();
    logic [3:0] pul;
    int lat;
    do_check(4'h5, pul, lat);
    n_tests++;
    if (pul !== 4'b0001 || lat !== 1) begin
      n_fail++;
      $display("FAIL empty_check: pulses=%b lat=%0d want 0001/1", pul, lat);
    end
    @(negedge clk);
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    n_tests++;
    if (play_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_play: play_done=%b busy=%b want 1/0", play_done, busy);
    end
  endtask

  task automatic test_reset_during_play();
    logic [3:0] snap [16];
    int lat, we0, diff;
    logic a, e;
    do_append(4'h5, lat, a, e);
    do_append(4'hA, lat, a, e);
    do_append(4'h3, lat, a, e);
    @(negedge clk);
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (show_valid !== 1'b1 || show_data !== 4'h5) begin
      n_fail++;
      $display("FAIL rst_play_pre: show_valid=%b data=%h want 1/5", show_valid, show_data);
    end
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    we0 = we_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (show_valid !== 1'b0 || busy !== 1'b0 || seq_len !== 5'd0 || show_data !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_play_async: show_valid=%b busy=%b len=%0d data=%h want 0/0/0/0",
               show_valid, busy, seq_len, show_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    diff = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) diff++;
    n_tests++;
    if (diff !== 0 || we_cnt !== we0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_play_ram: changed=%0d writes=%0d busy=%b want 0/0/0",
               diff, we_cnt - we0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_append();
    test_play();
    test_check_round();
    test_check_mismatch();
    test_full();
    test_clear_append();
    test_empty();
    test_reset_during_play();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
